// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: synchronises switches and mode, then drives the LED channels
// as off / static / round-robin cycle / breathe through a shared PWM engine.
module rgb_led_sequencer #(
  parameter int PWM_BITS    = 8,
  parameter int TICK_DIV    = 390625,
  parameter int DWELL_TICKS = 64
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [2:0]          SW,
  input  logic [1:0]          MODE,
  output logic [2:0]          rgb,
  output logic [2:0]          active_ch,
  output logic [PWM_BITS-1:0] duty
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = {PWM_BITS{1'b1}};
  localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0]       DWELL_LAST = DW'(DWELL_TICKS - 1);

  typedef enum logic [2:0] {S_OFF, S_STATIC, S_CYCLE, S_BRUP, S_BRDN} state_t;

  logic [2:0]          sw_m_q, sw_s_q;
  logic [1:0]          mode_m_q, mode_s_q;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  state_t              state_q, state_d, entry_state;
  logic [1:0]          ptr_q, ptr_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [2:0]          active_ch_q, active_ch_d;
  logic [2:0]          rgb_q, rgb_d;
  logic                tick, in_mode, pwm_on;

  function automatic logic [1:0] lowest_ch(input logic [2:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd0;
    return r;
  endfunction

  // Nearest enabled channel after p in R->G->B->R order; p itself if it is the only one.
  function automatic logic [1:0] next_ch(input logic [1:0] p, input logic [2:0] m);
    logic [1:0] r;
    logic [1:0] c;
    int idx;
    r = p;
    for (int k = 2; k >= 0; k--) begin
      idx = (int'(p) + k + 1) % 3;
      c   = idx[1:0];
      if (m[c]) r = c;
    end
    return r;
  endfunction

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign pwm_cnt_d  = pwm_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dwell_d     = dwell_q;
    duty_d      = duty_q;
    active_ch_d = 3'b000;
    entry_state = S_OFF;
    case (mode_s_q)
      2'b01:   entry_state = S_STATIC;
      2'b10:   entry_state = S_CYCLE;
      2'b11:   entry_state = S_BRUP;
      default: entry_state = S_OFF;
    endcase
    in_mode = (state_q == entry_state) || (entry_state == S_BRUP && state_q == S_BRDN);

    // A mode change wins over any tick on the same clock.
    if (!in_mode) begin
      state_d = entry_state;
      dwell_d = '0;
      duty_d  = '0;
      if (entry_state == S_CYCLE) ptr_d = lowest_ch(sw_s_q);
    end else begin
      case (state_q)
        S_CYCLE: begin
          if (sw_s_q != 3'b000) begin
            if (!sw_s_q[ptr_q]) begin
              ptr_d   = next_ch(ptr_q, sw_s_q);
              dwell_d = '0;
            end else if (tick) begin
              if (dwell_q == DWELL_LAST) begin
                ptr_d   = next_ch(ptr_q, sw_s_q);
                dwell_d = '0;
              end else begin
                dwell_d = dwell_q + 1'b1;
              end
            end
          end
        end
        S_BRUP: if (tick) begin
          if (duty_q == DUTY_MAX) state_d = S_BRDN;
          else                    duty_d  = duty_q + 1'b1;
        end
        S_BRDN: if (tick) begin
          if (duty_q == '0) state_d = S_BRUP;
          else              duty_d  = duty_q - 1'b1;
        end
        default: ;
      endcase
    end

    case (state_d)
      S_STATIC: begin
        duty_d      = DUTY_MAX;
        active_ch_d = sw_s_q;
      end
      S_CYCLE: begin
        duty_d      = DUTY_MAX;
        active_ch_d = (sw_s_q == 3'b000) ? 3'b000 : (3'b001 << ptr_d);
      end
      S_BRUP, S_BRDN: active_ch_d = sw_s_q;
      default: begin
        duty_d      = '0;
        active_ch_d = 3'b000;
      end
    endcase

    // Output register sees the next-state duty so rgb, duty and active_ch move together.
    pwm_on = (pwm_cnt_q < duty_d) || (duty_d == DUTY_MAX);
    rgb_d  = active_ch_d & {3{pwm_on}};
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sw_m_q      <= '0;
      sw_s_q      <= '0;
      mode_m_q    <= '0;
      mode_s_q    <= '0;
      tick_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      state_q     <= S_OFF;
      ptr_q       <= '0;
      dwell_q     <= '0;
      duty_q      <= '0;
      active_ch_q <= '0;
      rgb_q       <= '0;
    end else begin
      sw_m_q      <= SW;
      sw_s_q      <= sw_m_q;
      mode_m_q    <= MODE;
      mode_s_q    <= mode_m_q;
      tick_cnt_q  <= tick_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dwell_q     <= dwell_d;
      duty_q      <= duty_d;
      active_ch_q <= active_ch_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rgb       = rgb_q;
  assign active_ch = active_ch_q;
  assign duty      = duty_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer: behavioural model checked every clock, plus
// directed scenarios with hand-derived expectations for reset, cycle, breathe and mode changes.
module tb_rgb_led_sequencer;
  localparam int PB   = 4;
  localparam int TD   = 4;
  localparam int DT   = 3;
  localparam int DMAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    sw = 3'b000;
  logic [1:0]    mode = 2'b00;
  logic [2:0]    rgb_w, act_w;
  logic [PB-1:0] duty_w;

  int total = 0;
  int bad   = 0;

  // model state: cycles since reset, synchroniser pipeline, adopted mode and its variables
  int m_n, m_sw1, m_sw_s, m_mode1, m_mode_s, m_mode, m_ch, m_dwell, m_duty, m_up;
  int e_rgb, e_act, e_duty;

  rgb_led_sequencer #(.PWM_BITS(PB), .TICK_DIV(TD), .DWELL_TICKS(DT)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .SW        (sw),
    .MODE      (mode),
    .rgb       (rgb_w),
    .active_ch (act_w),
    .duty      (duty_w)
  );

  always #5 clk = ~clk;

  function automatic int lowest(int m);
    for (int c = 0; c < 3; c++) if (((m >> c) & 1) == 1) return c;
    return 0;
  endfunction

  function automatic int next_en(int c, int m);
    int t;
    for (int k = 1; k <= 3; k++) begin
      t = (c + k) % 3;
      if (((m >> t) & 1) == 1) return t;
    end
    return c;
  endfunction

  task automatic chk(string name, int actual, int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_sw1 = 0; m_sw_s = 0; m_mode1 = 0; m_mode_s = 0; m_mode = 0;
    m_ch = 0; m_dwell = 0; m_duty = 0; m_up = 1;
    e_rgb = 0; e_act = 0; e_duty = 0;
  endtask

  task automatic model_step();
    bit tk;
    int pwm, lit;
    tk  = (m_n % TD) == TD - 1;
    pwm = m_n % (DMAX + 1);
    if (m_mode_s != m_mode) begin
      m_mode = m_mode_s; m_up = 1; m_duty = 0; m_dwell = 0;
      if (m_mode == 2) m_ch = lowest(m_sw_s);
    end else if (m_mode == 2) begin
      if (m_sw_s != 0) begin
        if (((m_sw_s >> m_ch) & 1) == 0) begin
          m_ch = next_en(m_ch, m_sw_s); m_dwell = 0;
        end else if (tk) begin
          m_dwell++;
          if (m_dwell == DT) begin m_dwell = 0; m_ch = next_en(m_ch, m_sw_s); end
        end
      end
    end else if (m_mode == 3 && tk) begin
      if (m_up == 1) begin
        if (m_duty == DMAX) m_up = 0; else m_duty++;
      end else begin
        if (m_duty == 0) m_up = 1; else m_duty--;
      end
    end
    case (m_mode)
      0: begin e_duty = 0;      lit = 0; end
      1: begin e_duty = DMAX;   lit = m_sw_s; end
      2: begin e_duty = DMAX;   lit = (m_sw_s == 0) ? 0 : (1 << m_ch); end
      default: begin e_duty = m_duty; lit = m_sw_s; end
    endcase
    e_act = lit;
    e_rgb = (pwm < e_duty || e_duty == DMAX) ? lit : 0;
    m_sw_s = m_sw1;     m_sw1 = int'(sw);
    m_mode_s = m_mode1; m_mode1 = int'(mode);
    m_n++;
  endtask

  task automatic compare();
    chk("rgb", int'(rgb_w), e_rgb);
    chk("active_ch", int'(act_w), e_act);
    chk("duty", int'(duty_w), e_duty);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare();
  endtask

  task automatic run(int n);
    repeat (n) tick_clk();
  endtask

  task automatic assert_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_rgb", int'(rgb_w), 0);
    chk("async_rst_duty", int'(duty_w), 0);
    chk("async_rst_active_ch", int'(act_w), 0);
  endtask

  initial begin
    int ch_val[$];
    int ch_t[$];
    int d_val[$];
    int prev, ok, seen1, seen4, w, hi15, n15, exp_d;

    model_reset();
    run(3);
    rst_n = 1'b1;
    mode = 2'b01; sw = 3'b011;
    run(20);

    // 1: reset mid-run, release into static with R+B
    assert_reset();
    mode = 2'b01; sw = 3'b101;
    run(2);
    rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick_clk();
      if (i < 3) chk("static_latency_rgb_low", int'(rgb_w), 0);
      else begin
        chk("static_rgb", int'(rgb_w), 5);
        chk("static_duty", int'(duty_w), 15);
      end
    end

    // 2: cycle order and dwell
    mode = 2'b10; sw = 3'b111;
    prev = int'(act_w);
    for (int i = 1; i <= 45; i++) begin
      tick_clk();
      if (int'(act_w) != prev) begin
        prev = int'(act_w);
        ch_val.push_back(prev);
        ch_t.push_back(i);
      end
    end
    chk("cycle_change_count", (ch_val.size() >= 4) ? 4 : ch_val.size(), 4);
    if (ch_val.size() >= 4) begin
      chk("cycle_first_r", ch_val[0], 1);
      chk("cycle_then_g", ch_val[1], 2);
      chk("cycle_then_b", ch_val[2], 4);
      chk("cycle_wrap_r", ch_val[3], 1);
      chk("cycle_g_dwell", ch_t[2] - ch_t[1], 12);
      chk("cycle_b_dwell", ch_t[3] - ch_t[2], 12);
    end

    // 3: skip disabled channel, disable mid-dwell, empty mask
    sw = 3'b101;
    ok = 1; seen1 = 0; seen4 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick_clk();
      if (i > 3) begin
        if (act_w != 3'b001 && act_w != 3'b100) ok = 0;
        if (act_w == 3'b001) seen1 = 1;
        if (act_w == 3'b100) seen4 = 1;
      end
    end
    chk("skip_only_r_b", ok, 1);
    chk("skip_saw_both", seen1 & seen4, 1);
    w = 0;
    while (act_w != 3'b100 && w < 40) begin tick_clk(); w++; end
    chk("wait_b_granted", int'(act_w), 4);
    sw = 3'b001;
    run(3);
    chk("disable_b_regrant_r", int'(act_w), 1);
    run(14);
    chk("single_r_holds", int'(act_w), 1);
    sw = 3'b000;
    run(3);
    chk("empty_mask_rgb", int'(rgb_w), 0);
    chk("empty_mask_active", int'(act_w), 0);

    // 4: breathe on G
    mode = 2'b11; sw = 3'b010;
    prev = int'(duty_w);
    hi15 = 0; n15 = 0;
    for (int i = 1; i <= 150; i++) begin
      tick_clk();
      if (int'(duty_w) != prev) begin
        prev = int'(duty_w);
        d_val.push_back(prev);
      end
      if (duty_w == 4'hF && i > 3) begin
        n15++;
        if (rgb_w[1]) hi15++;
      end
    end
    chk("breathe_change_count", (d_val.size() >= 32) ? 32 : d_val.size(), 32);
    if (d_val.size() >= 32) begin
      for (int i = 0; i < 32; i++) begin
        exp_d = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
        chk("breathe_step", d_val[i], exp_d);
      end
    end
    chk("breathe_top_clocks", n15, 8);
    chk("breathe_top_full_on", hi15, 8);

    // 5: mode change landing on a tick edge
    w = 0;
    while ((m_n % TD) != 1 && w < 8) begin tick_clk(); w++; end
    chk("tick_align", m_n % TD, 1);
    mode = 2'b10;
    run(2);
    tick_clk();
    chk("prio_duty_full", int'(duty_w), 15);
    chk("prio_active_g", int'(act_w), 2);
    chk("prio_rgb_g", int'(rgb_w), 2);
    mode = 2'b00;
    run(2);
    chk("off_latency_duty_held", int'(duty_w), 15);
    tick_clk();
    chk("off_rgb", int'(rgb_w), 0);
    chk("off_duty", int'(duty_w), 0);
    chk("off_active", int'(act_w), 0);

    // randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      tick_clk();
      if ($urandom_range(7) == 0) sw = 3'($urandom_range(7));
      if ($urandom_range(29) == 0) mode = 2'($urandom_range(3));
      if (i == 300) begin
        assert_reset();
        run(2);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
- Controller that decides which colour channels of the single on-board RGB LED are lit, and at what brightness.
- Time-shares the LED between the three channels selected on the switches. Four modes: off, static, round-robin cycle, breathe.
- Contains its own tick prescaler, PWM engine, input synchronisers and mode FSM. Sits between board switches and the rgb output pins, and replaces ad-hoc combinational gating of rgb by a divided clock.

Parameters:
- PWM_BITS, 8, width of PWM counter and duty register; PWM period = 2^PWM_BITS clocks.
- TICK_DIV, 390625, clocks per sequencing tick (>=2).
- DWELL_TICKS, 64, ticks each channel stays lit in cycle mode (>=1).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESETN  input  1  asynchronous active-low reset.
- SW  input  3  channel enable mask, bit0=R, bit1=G, bit2=B; asynchronous to the clock.
- MODE  input  2  00 off, 01 static, 10 cycle, 11 breathe; asynchronous to the clock.
- rgb  output  3  LED drive, registered.
- active_ch  output  3  one-hot channel currently granted in cycle mode; equals the mask in static/breathe; 0 in off.
- duty  output  PWM_BITS  current duty value.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (CPU_RESETN).
- Reset values: rgb=0, active_ch=0, duty=0, pwm_cnt=0, tick prescaler=0, dwell counter=0, channel pointer=0, FSM=S_OFF, synchronisers=0.
- Synchronisers:
  - SW and MODE each pass through 2 flops (sw_s, mode_s). All logic uses only the synchronised values.
  - Latency from input change to rgb change is 3 clocks: 2 sync + 1 output register.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a 1-clock pulse when the count equals TICK_DIV-1.
  - Runs in every state.
- PWM engine:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps.
  - Channel i is lit when lit_mask[i]=1 AND (pwm_cnt < duty OR duty == all-ones). Therefore all-ones means 100% on and 0 means always off.
  - rgb is registered from this condition.
- FSM states: S_OFF, S_STATIC, S_CYCLE, S_BRUP, S_BRDN.
  - mode_s has priority over tick. On a change of mode_s, the FSM goes next clock to S_OFF / S_STATIC / S_CYCLE / S_BRUP respectively.
  - S_OFF: lit_mask=0, duty=0.
  - S_STATIC: lit_mask=sw_s, duty=all-ones.
  - S_CYCLE:
    - duty=all-ones, lit_mask=active_ch.
    - On entry, pointer = lowest set bit of sw_s and dwell counter = 0.
    - On each tick the dwell counter increments. When it reaches DWELL_TICKS-1 at a tick, the counter clears and the pointer advances to the next enabled channel in the order R->G->B->R, skipping disabled channels.
    - With a single enabled channel, the pointer stays on it.
    - If sw_s==0: active_ch=0 and rgb=0; the pointer holds.
    - If the granted channel is disabled mid-dwell: the pointer advances on the next clock (no tick needed) and the dwell counter clears.
  - S_BRUP:
    - lit_mask=sw_s.
    - On entry duty=0.
    - duty increments by 1 per tick. A tick at duty==all-ones moves to S_BRDN with duty held.
  - S_BRDN:
    - duty decrements by 1 per tick. A tick at duty==0 moves to S_BRUP with duty held.
    - A full breathe period is 2*2^PWM_BITS ticks.
- Widths: the dwell counter is sized ceil(log2(DWELL_TICKS+1)). duty never wraps (no increment past all-ones, no decrement past 0).
- Reset mid-operation: all state returns to the reset values immediately, asynchronously. After reset release, rgb stays 0 until the synchronised inputs propagate.

Test Plan:
(Use PWM_BITS=4, TICK_DIV=4, DWELL_TICKS=3.)
1. Reset and static mode. Assert CPU_RESETN=0 mid-run -> rgb=0, duty=0, active_ch=0 the same cycle. Release with MODE=01, SW=101 -> rgb=101 continuously from the 3rd clock on, duty=4'hF.
2. Cycle order and timing. MODE=10, SW=111 -> active_ch sequence 001,010,100,001, each held 12 clocks (3 ticks x 4). rgb equals active_ch.
3. Cycle with skip and mid-dwell disable.
   - SW=101 -> active_ch alternates 001 and 100 only.
   - Clearing SW[2] while 100 is granted -> active_ch=001 within 3 clocks, and the dwell restarts.
   - SW=000 -> rgb=0.
4. Breathe. MODE=11, SW=010 -> duty steps 0,1,...,15,14,...,0,1, changing once per 4 clocks. At duty=5, rgb[1] is high exactly 5 of every 16 clocks. At duty=15, rgb[1] is high all 16.
5. Mode change priority. Switch MODE 11->10 on the same clock as a tick -> FSM enters S_CYCLE, duty=4'hF, and no duty step is applied. Then MODE=00 -> rgb=0 and duty=0 after 3 clocks.
